// File: rtl/montre_jtag_debug_sysclk_cmdq.sv
// System-clock-side JTAG debug command queue: synchronises update-DR/IR strobes, buffers
// {ir, data} commands and issues per-channel action strobes. Optional: JTAG_CMDQ_OVF_EN.
module montre_jtag_debug_sysclk_cmdq #(
  parameter int unsigned DATA_W      = 38,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACTION_BIT  = 37
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     vs_udr_i,
  input  logic                     vs_uir_i,
  input  logic [IR_W-1:0]          ir_in_i,
  input  logic [DATA_W-1:0]        sr_i,
  input  logic                     cmd_ready_i,
  output logic                     cmd_valid_o,
  output logic [IR_W-1:0]          cmd_ir_o,
  output logic [DATA_W-1:0]        jdo_o,
  output logic [(2**IR_W)-1:0]     take_action_o,
  output logic [(2**IR_W)-1:0]     take_no_action_o,
  output logic [IR_W-1:0]          ir_shadow_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  input  logic                     overflow_clr_i
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned NACT = 2 ** IR_W;

  // ---------------------------------------------------------------------------
  // Strobe synchronisers and rising-edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic                   udr_prev_q, uir_prev_q;
  logic                   udr_s, uir_s;
  logic                   udr_rise, uir_rise;

  // Reset to all-ones so a level already high at release is not seen as an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      udr_sync_q <= '1;
      uir_sync_q <= '1;
      udr_prev_q <= 1'b1;
      uir_prev_q <= 1'b1;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr_i};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir_i};
      udr_prev_q <= udr_s;
      uir_prev_q <= uir_s;
    end
  end

  always_comb begin
    udr_s    = udr_sync_q[SYNC_STAGES-1];
    uir_s    = uir_sync_q[SYNC_STAGES-1];
    udr_rise = udr_s & ~udr_prev_q;
    uir_rise = uir_s & ~uir_prev_q;
  end

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [IR_W-1:0]   mem_ir_q   [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              fifo_empty, fifo_full;
  logic              push, pop, drop;
  logic [IR_W-1:0]   head_ir;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LW'(DEPTH));
    head_ir    = mem_ir_q[rd_ptr_q];
    head_data  = mem_data_q[rd_ptr_q];
    pop        = !fifo_empty && cmd_ready_i;
    // A simultaneous pop frees a slot, so a push into a full queue still lands.
    push       = udr_rise && (!fifo_full || pop);
    drop       = udr_rise && fifo_full && !pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; the empty state is defined by the pointers and level.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_ir_q[wr_ptr_q]   <= ir_in_i;
      mem_data_q[wr_ptr_q] <= sr_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Dequeue outputs: data word and per-channel strobes
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] jdo_q, jdo_d;
  logic [NACT-1:0]   act_q, act_d;
  logic [NACT-1:0]   nact_q, nact_d;
  logic [IR_W-1:0]   shadow_q, shadow_d;

  always_comb begin
    jdo_d    = jdo_q;
    act_d    = '0;
    nact_d   = '0;
    shadow_d = shadow_q;
    if (pop) begin
      jdo_d = head_data;
      if (head_data[ACTION_BIT]) begin
        act_d[head_ir] = 1'b1;
      end else begin
        nact_d[head_ir] = 1'b1;
      end
    end
    if (uir_rise) begin
      shadow_d = ir_in_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      jdo_q    <= '0;
      act_q    <= '0;
      nact_q   <= '0;
      shadow_q <= '0;
    end else begin
      jdo_q    <= jdo_d;
      act_q    <= act_d;
      nact_q   <= nact_d;
      shadow_q <= shadow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow tracking
  // ---------------------------------------------------------------------------
`ifdef JTAG_CMDQ_OVF_EN
  logic ovf_q, ovf_d;

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (overflow_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_o = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = drop ^ overflow_clr_i;
  assign overflow_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_valid_o      = !fifo_empty;
    cmd_ir_o         = fifo_empty ? '0 : head_ir;
    jdo_o            = jdo_q;
    take_action_o    = act_q;
    take_no_action_o = nact_q;
    ir_shadow_o      = shadow_q;
    level_o          = level_q;
  end

endmodule

// File: tb/tb_montre_jtag_debug_sysclk_cmdq.sv
// Scoreboard bench: queue-based reference model predicts every dequeued command; a monitor
// compares the DUT each cycle. Directed test-plan steps followed by randomized traffic.
module tb_montre_jtag_debug_sysclk_cmdq;

  localparam int unsigned DATA_W = 38;
  localparam int unsigned IR_W   = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned S      = 2;
  localparam int unsigned ACT    = 37;
  localparam int unsigned NACT   = 1 << IR_W;
  localparam int unsigned LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              vs_udr = 1'b0;
  logic              vs_uir = 1'b0;
  logic              cmd_ready = 1'b0;
  logic              ovf_clr = 1'b0;
  logic [IR_W-1:0]   ir_in = '0;
  logic [DATA_W-1:0] sr = '0;

  logic              cmd_valid;
  logic [IR_W-1:0]   cmd_ir;
  logic [DATA_W-1:0] jdo;
  logic [NACT-1:0]   take_action;
  logic [NACT-1:0]   take_no_action;
  logic [IR_W-1:0]   ir_shadow;
  logic [LW-1:0]     level;
  logic              overflow;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          rnd_ready = 1'b0;
  bit          rnd_clr = 1'b0;

  montre_jtag_debug_sysclk_cmdq #(
    .DATA_W     (DATA_W),
    .IR_W       (IR_W),
    .DEPTH      (DEPTH),
    .SYNC_STAGES(S),
    .ACTION_BIT (ACT)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .vs_udr_i        (vs_udr),
    .vs_uir_i        (vs_uir),
    .ir_in_i         (ir_in),
    .sr_i            (sr),
    .cmd_ready_i     (cmd_ready),
    .cmd_valid_o     (cmd_valid),
    .cmd_ir_o        (cmd_ir),
    .jdo_o           (jdo),
    .take_action_o   (take_action),
    .take_no_action_o(take_no_action),
    .ir_shadow_o     (ir_shadow),
    .level_o         (level),
    .overflow_o      (overflow),
    .overflow_clr_i  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a JTAG update is detected when the level rises, lands in the
  // queue S clocks later, and a pop occurs whenever the queue is non-empty and ready.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] d;
  } cmd_t;

  typedef struct {
    int unsigned       due;
    bit                is_ir;
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] d;
  } pend_t;

  cmd_t              mq[$];
  cmd_t              exp_q[$];
  pend_t             pend[$];
  int unsigned       cyc = 0;
  bit                udr_prev = 1'b1;
  bit                uir_prev = 1'b1;
  logic [IR_W-1:0]   m_shadow = '0;
  logic [DATA_W-1:0] m_jdo = '0;
  bit                m_ovf = 1'b0;
  bit                m_pop, m_full, m_drop;
  cmd_t              m_e;
  pend_t             m_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      pend.delete();
      cyc      = 0;
      udr_prev = 1'b1;
      uir_prev = 1'b1;
      m_shadow = '0;
      m_jdo    = '0;
      m_ovf    = 1'b0;
    end else begin
      cyc++;
      m_pop  = (mq.size() != 0) && cmd_ready;
      m_full = (mq.size() == DEPTH);
      m_drop = 1'b0;
      if (m_pop) begin
        m_e   = mq.pop_front();
        m_jdo = m_e.d;
        exp_q.push_back(m_e);
      end
      while (pend.size() != 0 && pend[0].due == cyc) begin
        m_p = pend.pop_front();
        if (m_p.is_ir) m_shadow = m_p.ir;
        else if (m_full && !m_pop) m_drop = 1'b1;
        else mq.push_back('{m_p.ir, m_p.d});
      end
`ifdef JTAG_CMDQ_OVF_EN
      if (m_drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
`endif
      if (vs_udr && !udr_prev) pend.push_back('{cyc + S, 1'b0, ir_in, sr});
      if (vs_uir && !uir_prev) pend.push_back('{cyc + S, 1'b1, ir_in, sr});
      udr_prev = vs_udr;
      uir_prev = vs_uir;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compare every cycle, pop the scoreboard on each expected dequeue
  // ---------------------------------------------------------------------------
  cmd_t            mon_e;
  logic [NACT-1:0] ea, ena;
  logic [IR_W-1:0] e_ir;

  always @(negedge clk) begin
    if (rst_n) begin
      e_ir = '0;
      if (mq.size() != 0) e_ir = mq[0].ir;
      check("level", 64'(level), 64'(mq.size()));
      check("cmd_valid", 64'(cmd_valid), 64'(mq.size() != 0));
      check("cmd_ir", 64'(cmd_ir), 64'(e_ir));
      check("ir_shadow", 64'(ir_shadow), 64'(m_shadow));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("jdo", 64'(jdo), 64'(m_jdo));
      ea  = '0;
      ena = '0;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        if (mon_e.d[ACT]) ea[mon_e.ir] = 1'b1;
        else ena[mon_e.ir] = 1'b1;
      end
      check("take_action", 64'(take_action), 64'(ea));
      check("take_no_action", 64'(take_no_action), 64'(ena));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    if (rnd_ready) cmd_ready = 1'($urandom_range(0, 1));
    if (rnd_clr) ovf_clr = ($urandom_range(0, 7) == 0);
  endtask

  // Called at a falling edge; optionally asserts cmd_ready only for the push edge.
  task automatic pulse_udr(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] d,
                           input bit pop_at_push = 1'b0);
    ir_in  = ir;
    sr     = d;
    vs_udr = 1'b1;
    repeat (S) tick();
    if (pop_at_push) cmd_ready = 1'b1;
    tick();
    if (pop_at_push) cmd_ready = 1'b0;
    vs_udr = 1'b0;
    repeat (S + 1) tick();
  endtask

  task automatic pulse_uir(input logic [IR_W-1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    repeat (S + 1) tick();
    vs_uir = 1'b0;
    repeat (S + 1) tick();
  endtask

  logic [63:0] rnd;

  initial begin
    // Level already high across reset release must not push.
    vs_udr = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();
    check("no_push_after_reset", 64'(level), 64'd0);
    vs_udr = 1'b0;
    repeat (S + 1) tick();

    cmd_ready = 1'b1;
    pulse_udr(2'd2, 38'h20_0000_00AB);
    check("jdo_action", 64'(jdo), 64'h20_0000_00AB);
    pulse_udr(2'd1, 38'h00_0000_0055);
    check("jdo_no_action", 64'(jdo), 64'h00_0000_0055);
    cmd_ready = 1'b0;

    for (int i = 1; i <= 5; i++) pulse_udr(IR_W'(i), DATA_W'(i));
    check("level_full", 64'(level), 64'(DEPTH));
`ifdef JTAG_CMDQ_OVF_EN
    check("overflow_set", 64'(overflow), 64'd1);
`else
    check("overflow_tied", 64'(overflow), 64'd0);
`endif
    cmd_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    cmd_ready = 1'b0;
    check("drain_last", 64'(jdo), 64'd4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
    check("overflow_clr", 64'(overflow), 64'd0);

    for (int i = 0; i < 4; i++) pulse_udr(IR_W'(i), 38'h20_0000_0100 + DATA_W'(i));
    pulse_udr(2'd3, 38'h3F_FFFF_FFFF, 1'b1);
    check("full_push_pop_level", 64'(level), 64'(DEPTH));
    check("full_push_pop_ovf", 64'(overflow), 64'd0);
    cmd_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    cmd_ready = 1'b0;
    check("full_push_pop_tail", 64'(jdo), 64'h3F_FFFF_FFFF);

    pulse_udr(2'd0, 38'h11);
    pulse_udr(2'd1, 38'h22);
    pulse_uir(2'd3);
    check("ir_shadow_dir", 64'(ir_shadow), 64'd3);
    check("uir_no_push", 64'(level), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_level", 64'(level), 64'd0);
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_strobes", 64'({take_action, take_no_action}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (S + 2) tick();

    rnd_ready = 1'b1;
    rnd_clr   = 1'b1;
    for (int n = 0; n < 200; n++) begin
      rnd = {$urandom(), $urandom()};
      if ($urandom_range(0, 9) == 0) pulse_uir(IR_W'($urandom_range(0, NACT - 1)));
      else pulse_udr(IR_W'($urandom_range(0, NACT - 1)), rnd[DATA_W-1:0]);
    end
    rnd_ready = 1'b0;
    rnd_clr   = 1'b0;
    ovf_clr   = 1'b0;
    cmd_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    check("final_empty", 64'(level), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/montre_jtag_debug_sysclk_cmdq.md
# montre_jtag_debug_sysclk_cmdq

System-clock-side command queue for the Nios II JTAG debug module. It synchronises the update-DR / update-IR strobes arriving from the TCK domain, captures the shifted data word and instruction into a FIFO, and hands one command at a time to the OCI core. For each dequeued command it emits one-cycle take_action / take_no_action strobes per instruction channel. It succeeds the fixed-width, unbuffered sysclk decoder: width, IR size and depth are parameters, and back-to-back JTAG updates are queued rather than lost.

## Interface
- DATA_W, 38: width of the scanned data word (sr / jdo)
- IR_W, 2: instruction width; 2**IR_W action channels
- DEPTH, 4: FIFO entries, power of two, ≥2
- SYNC_STAGES, 2: synchroniser flops on vs_udr / vs_uir, ≥2
- ACTION_BIT, 37: bit of the data word that selects action vs no-action
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- vs_udr  in  1  update-DR level from TCK domain (asynchronous)
- vs_uir  in  1  update-IR level from TCK domain (asynchronous)
- ir_in  in  IR_W  current instruction, stable around vs_udr/vs_uir
- sr  in  DATA_W  shifted data, stable while vs_udr high
- cmd_ready  in  1  consumer accepts head command this cycle
- cmd_valid  out  1  FIFO non-empty
- cmd_ir  out  IR_W  instruction of head entry
- jdo  out  DATA_W  data of last dequeued command (registered)
- take_action  out  2**IR_W  one-hot, one-cycle strobe
- take_no_action  out  2**IR_W  one-hot, one-cycle strobe
- ir_shadow  out  IR_W  instruction latched on last vs_uir edge
- level  out  $clog2(DEPTH)+1  entry count
- overflow  out  1  sticky: a push was dropped
- overflow_clr  in  1  clears overflow

## Operation
- Reset values: all synchroniser and edge-history flops = 1 (suppresses a spurious edge if vs_udr/vs_uir is high at reset release); FIFO empty, level 0, cmd_valid 0, cmd_ir 0, jdo 0, strobes 0, ir_shadow 0, overflow 0.
- Rising edge on synchronised vs_udr: push {ir_in, sr} sampled that cycle.
- Rising edge on synchronised vs_uir: ir_shadow <= ir_in; no push.
- Pop when cmd_valid && cmd_ready. Next cycle: jdo <= popped data; with i = popped ir, take_action[i] = 1 if data[ACTION_BIT] else take_no_action[i] = 1; every other strobe bit 0.
- Push while full without a pop: entry dropped, contents unchanged, overflow set.
- Push and pop in the same cycle: both succeed, including when full; level unchanged.
- Pop while empty: ignored; cmd_ready is don't-care.
- overflow_clr and drop in the same cycle: overflow stays 1 (set wins).
- Pointers wrap modulo DEPTH; level is distinct for full (DEPTH) and empty (0).
- Reset asserted mid-operation: queue flushed immediately, strobes forced low, no partial command emitted after release.

## Timing
- vs_udr rising before clk edge N (meets setup): synchroniser output high at edge N+SYNC_STAGES-1, push at edge N+SYNC_STAGES, cmd_valid high after that edge.
- Pop at edge P: jdo and strobe valid from P to P+1; strobe deasserts at P+1 unless another pop occurred at P+1.
- Continuous cmd_ready: one command per cycle; strobes may then be high on consecutive cycles.
- vs_udr high pulse must last ≥ SYNC_STAGES+1 clk cycles and stay low ≥ SYNC_STAGES+1 cycles; shorter pulses are undefined.
- cmd_valid, cmd_ir, level update the cycle after a push or pop.

## Configuration
- JTAG_CMDQ_OVF_EN defined: overflow detection and overflow_clr as specified.
- Not defined: drops happen silently; overflow tied 0; overflow_clr ignored; no flop for overflow.

## Test plan
- Reset with vs_udr held 1, release, hold 1 for 10 cycles -> no push, level 0, all strobes 0.
- ir_in=2, sr=38'h20_0000_00AB, vs_udr pulse, cmd_ready=1 -> cmd_valid after SYNC_STAGES+1 cycles; next cycle jdo=38'h20_0000_00AB, take_action=4'b0100 for one cycle.
- sr bit37=0, ir_in=1 -> take_no_action=4'b0010 only, take_action=0.
- cmd_ready=0, 5 vs_udr pulses with data 1..5 (DEPTH=4) -> level 4, overflow=1 (with macro); drain -> jdo 1,2,3,4 in order, entry 5 absent; overflow_clr -> overflow 0.
- FIFO full, push and pop on same cycle -> level stays 4, both entries correct, overflow stays 0.
- vs_uir pulse with ir_in=3 -> ir_shadow=3, level unchanged; reset asserted with 2 entries queued -> level 0, cmd_valid 0 immediately.
